// File: rtl/sid_env_follow.sv
// Envelope follower: tracks the magnitude of a signed 12-bit audio stream as an
// 8-bit SID-style envelope. Optional macro ENV_FOLLOW_EXP_EN enables the exponential release curve.
module sid_env_follow #(
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] sample,
  input  logic [3:0]  attack_rate,
  input  logic [3:0]  release_rate,
  output logic [7:0]  env,
  output logic        env_strobe,
  output logic [1:0]  state_o
);

  localparam int unsigned ENV_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [ENV_W-1:0]    env_n;
  logic [ENV_W-1:0]    target, target_n;
  logic [ENV_W-1:0]    last_mag, last_mag_n;
  logic [CNT_W-1:0]    rate_counter, rate_counter_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [11:0]         abs_val;
  logic [ENV_W-1:0]    mag;
  logic [3:0]          sel_rate;
  logic [CNT_W-1:0]    period;
  logic                tick;
  logic                rise;

`ifdef ENV_FOLLOW_EXP_EN
  logic [4:0]          exp_div, exp_div_n;
  logic [4:0]          exp_period, exp_period_n;
`endif

  // SID rate-period table
  function automatic logic [CNT_W-1:0] rate_period(input logic [3:0] r);
    case (r)
      4'd0:  rate_period = 16'd9;
      4'd1:  rate_period = 16'd32;
      4'd2:  rate_period = 16'd63;
      4'd3:  rate_period = 16'd95;
      4'd4:  rate_period = 16'd149;
      4'd5:  rate_period = 16'd220;
      4'd6:  rate_period = 16'd267;
      4'd7:  rate_period = 16'd313;
      4'd8:  rate_period = 16'd392;
      4'd9:  rate_period = 16'd977;
      4'd10: rate_period = 16'd1954;
      4'd11: rate_period = 16'd3126;
      4'd12: rate_period = 16'd3907;
      4'd13: rate_period = 16'd11720;
      4'd14: rate_period = 16'd19532;
      default: rate_period = 16'd31251;
    endcase
  endfunction

  // Saturated magnitude: only -2048 sets abs_val[11]
  always_comb begin
    abs_val  = sample[11] ? 12'(~sample + 12'd1) : sample;
    mag      = abs_val[11] ? 8'hFF : 8'(abs_val >> 3);
    sel_rate = (state == RELEASE || state == HOLD) ? release_rate : attack_rate;
    period   = rate_period(sel_rate);
    tick     = (rate_counter >= period);
    rise     = sample_valid && (mag > env);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      env          <= '0;
      env_strobe   <= 1'b0;
      target       <= '0;
      last_mag     <= '0;
      rate_counter <= '0;
      hold_cnt     <= '0;
`ifdef ENV_FOLLOW_EXP_EN
      exp_div      <= '0;
      exp_period   <= 5'd1;
`endif
    end else begin
      state        <= state_n;
      env          <= env_n;
      env_strobe   <= (env_n != env);
      target       <= target_n;
      last_mag     <= last_mag_n;
      rate_counter <= rate_counter_n;
      hold_cnt     <= hold_cnt_n;
`ifdef ENV_FOLLOW_EXP_EN
      exp_div      <= exp_div_n;
      exp_period   <= exp_period_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    env_n          = env;
    target_n       = target;
    last_mag_n     = last_mag;
    hold_cnt_n     = hold_cnt;
    rate_counter_n = tick ? '0 : rate_counter + 16'd1;
`ifdef ENV_FOLLOW_EXP_EN
    exp_div_n      = exp_div;
    exp_period_n   = exp_period;
    case (env)
      8'hFF: exp_period_n = 5'd1;
      8'h5D: exp_period_n = 5'd2;
      8'h36: exp_period_n = 5'd4;
      8'h1A: exp_period_n = 5'd8;
      8'h0E: exp_period_n = 5'd16;
      8'h06: exp_period_n = 5'd30;
      8'h00: exp_period_n = 5'd1;
      default: ;
    endcase
`endif

    if (sample_valid) last_mag_n = mag;

    case (state)
      IDLE: begin
        env_n = '0;
        if (sample_valid && mag != '0) begin
          state_n  = ATTACK;
          target_n = mag;
        end
      end
      ATTACK: begin
        if (sample_valid && mag > target) target_n = mag;
        if (tick) begin
          if (env < target) begin
            env_n = env + 8'd1;
          end else begin
            state_n    = HOLD;
            hold_cnt_n = '0;
          end
        end
      end
      HOLD: begin
        if (rise) begin
          state_n  = ATTACK;
          target_n = mag;
        end else if (tick) begin
          hold_cnt_n = hold_cnt + 8'd1;
          if (hold_cnt == 8'(HOLD_TICKS - 1)) begin
            state_n  = RELEASE;
            target_n = last_mag;
          end
        end
      end
      RELEASE: begin
        if (sample_valid) target_n = mag;
        // Step decisions use the pre-update target; a rising sample wins the transition
        if (tick) begin
          if (env > target) begin
`ifdef ENV_FOLLOW_EXP_EN
            if (exp_div == exp_period - 5'd1) begin
              env_n     = env - 8'd1;
              exp_div_n = '0;
            end else begin
              exp_div_n = exp_div + 5'd1;
            end
`else
            env_n = env - 8'd1;
`endif
          end else if (!rise) begin
            state_n    = (target == '0) ? IDLE : HOLD;
            hold_cnt_n = '0;
          end
        end
        if (rise) state_n = ATTACK;
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state) rate_counter_n = '0;
`ifdef ENV_FOLLOW_EXP_EN
    if (state_n == RELEASE && state != RELEASE) exp_div_n = '0;
`endif
  end

  assign state_o = state;

endmodule
